// File: rtl/glb_pkg.sv
// Shared address-map types and helpers for the multibank global buffer.
package glb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_BANK_DEPTH = 4096;

  localparam int BYTE_OFS_W = $clog2(DEF_DATA_WIDTH / 8);
  localparam int BANK_W     = $clog2(DEF_NUM_BANKS);
  localparam int ROW_W      = $clog2(DEF_BANK_DEPTH);

  // Location fields are sized for the largest supported configuration
  // (16 banks, 64-bit byte addresses); callers slice what they need.
  localparam int LOC_ADDR_W = 64;
  localparam int LOC_BANK_W = 4;

  typedef struct packed {
    logic                  oob;
    logic [LOC_BANK_W-1:0] bank;
    logic [LOC_ADDR_W-1:0] row;
  } glb_loc_t;

  // Word-interleaved map: low word bits pick the bank, the rest pick the row.
  function automatic glb_loc_t addr_to_bank_row(input logic [LOC_ADDR_W-1:0] addr,
                                                input int ofs_w,
                                                input int bank_w,
                                                input int row_w);
    logic [LOC_ADDR_W-1:0] word;
    glb_loc_t loc;
    word     = addr >> ofs_w;
    loc.oob  = |(word >> (bank_w + row_w));
    loc.bank = LOC_BANK_W'(word & ((LOC_ADDR_W'(1) << bank_w) - LOC_ADDR_W'(1)));
    loc.row  = (word >> bank_w) & ((LOC_ADDR_W'(1) << row_w) - LOC_ADDR_W'(1));
    return loc;
  endfunction

endpackage

// File: rtl/glb_multibank_bank.sv
// One storage bank: bit-masked write port and registered read port.
module glb_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [DATA_WIDTH-1:0]    wbweb,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Merge new data into the stored word only where the active-low mask is 0.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= (mem[waddr] & wbweb) | (wdata & ~wbweb);
  end

  // Registered read; the output holds between reads of this bank.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/glb_multibank.sv
// Word-interleaved multibank global buffer with read/write handshakes,
// configurable read latency, out-of-range flagging and a stall counter.
module glb_multibank
  import glb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 4096,
  parameter int RD_LAT     = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_bweb,
  output logic                  err_oob,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam int OFS_W = $clog2(DATA_WIDTH / 8);
  localparam int B_W   = $clog2(NUM_BANKS);
  localparam int R_W   = $clog2(BANK_DEPTH);
  localparam int SEL_W = (B_W > 0) ? B_W : 1;

  glb_loc_t              rd_loc, wr_loc;
  logic                  conflict, rd_acc;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic                  s0_valid, s0_oob;
  logic [SEL_W-1:0]      s0_bank;
  logic [DATA_WIDTH-1:0] mux_data, out_data, hold_data;
  logic                  out_valid, err_q;
  logic [CNT_WIDTH-1:0]  stall_q;

  // Decode both request addresses into bank/row/out-of-range.
  always_comb begin
    rd_loc = addr_to_bank_row(LOC_ADDR_W'(rd_addr), OFS_W, B_W, R_W);
    wr_loc = addr_to_bank_row(LOC_ADDR_W'(wr_addr), OFS_W, B_W, R_W);
  end

  // Writes always win a same-bank collision; the read retries next cycle.
  assign conflict     = wr_valid && rd_req_valid && (rd_loc.bank == wr_loc.bank);
  assign rd_req_ready = !conflict;
  assign wr_ready     = 1'b1;
  assign rd_acc       = rd_req_valid && !conflict;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    glb_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(BANK_DEPTH)) u_bank (
      .clk   (clk),
      .we    (wr_valid && !rst && !wr_loc.oob && (wr_loc.bank == LOC_BANK_W'(b))),
      .waddr (wr_loc.row[R_W-1:0]),
      .wdata (wr_data),
      .wbweb (wr_bweb),
      .re    (rd_acc && !rd_loc.oob && (rd_loc.bank == LOC_BANK_W'(b))),
      .raddr (rd_loc.row[R_W-1:0]),
      .rdata (bank_rdata[b])
    );
  end

  // Track which bank (if any) feeds the first response stage.
  always_ff @(posedge clk) begin
    s0_oob  <= rd_loc.oob;
    s0_bank <= rd_loc.bank[SEL_W-1:0];
    if (rst) s0_valid <= 1'b0;
    else     s0_valid <= rd_acc;
  end

  // Out-of-range reads return zero instead of bank data.
  always_comb begin
    mux_data = '0;
    if (!s0_oob) mux_data = bank_rdata[s0_bank];
  end

  if (RD_LAT == 1) begin : g_lat1
    assign out_valid = s0_valid;
    assign out_data  = mux_data;
  end else begin : g_latn
    logic [RD_LAT-2:0]     sh_valid;
    logic [DATA_WIDTH-1:0] sh_data [RD_LAT-1];

    // Extra delay stages to stretch the response to RD_LAT cycles.
    always_ff @(posedge clk) begin
      sh_data[0] <= mux_data;
      for (int k = RD_LAT - 2; k > 0; k--) sh_data[k] <= sh_data[k-1];
      if (rst) begin
        sh_valid <= '0;
      end else begin
        sh_valid[0] <= s0_valid;
        for (int k = RD_LAT - 2; k > 0; k--) sh_valid[k] <= sh_valid[k-1];
      end
    end

    assign out_valid = sh_valid[RD_LAT-2];
    assign out_data  = sh_data[RD_LAT-2];
  end

  // Keep the last delivered word visible while no response is valid.
  always_ff @(posedge clk) begin
    if (rst)            hold_data <= '0;
    else if (out_valid) hold_data <= out_data;
  end

  assign rd_rsp_valid = out_valid;
  assign rd_rsp_data  = out_valid ? out_data : hold_data;

  // Error pulse one cycle after an out-of-range accept; saturating stall count.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      err_q <= (rd_acc && rd_loc.oob) || (wr_valid && wr_loc.oob);
      if (rd_req_valid && !rd_req_ready && !(&stall_q)) stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign err_oob   = err_q;
  assign stall_cnt = stall_q;

endmodule
